// File: rtl/datapath_controller_if.sv
// Instruction stream between the instruction source and datapath_controller.
interface datapath_controller_if;
  logic        instr_valid;
  logic [23:0] instr;
  logic        instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/datapath_controller.sv
// Decodes 24-bit instruction words and sequences the datapath's register-file
// write: IDLE -> SETUP (selects launched) -> WRITE (single write strobe) -> IDLE.
module datapath_controller #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_controller_if.slave instrIf,
  output logic                 writeEnable,
  output logic                 muxSel,
  output logic [7:0]           inputData,
  output logic [3:0]           dstSel,
  output logic [3:0]           A_sel,
  output logic [3:0]           B_sel,
  output logic [3:0]           OP_Sel,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [3:0] KIND_NOP   = 4'h0;
  localparam logic [3:0] KIND_LOADI = 4'h1;
  localparam logic [3:0] KIND_ALU   = 4'h2;
  localparam logic [3:0] KIND_HALT  = 4'hF;

  logic [1:0] state;
  logic [3:0] kind;
  logic       accept;

  assign kind                = instrIf.instr[23:20];
  assign instrIf.instr_ready = (state == IDLE);
  assign accept              = instrIf.instr_valid && instrIf.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      muxSel    <= 1'b0;
      inputData <= '0;
      dstSel    <= '0;
      A_sel     <= '0;
      B_sel     <= '0;
      OP_Sel    <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      retired   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (kind)
              KIND_NOP: ;
              KIND_LOADI: begin
                state     <= SETUP;
                dstSel    <= instrIf.instr[19:16];
                A_sel     <= '0;
                B_sel     <= '0;
                OP_Sel    <= '0;
                muxSel    <= 1'b1;
                inputData <= instrIf.instr[7:0];
              end
              KIND_ALU: begin
                state     <= SETUP;
                dstSel    <= instrIf.instr[19:16];
                A_sel     <= instrIf.instr[15:12];
                B_sel     <= instrIf.instr[11:8];
                OP_Sel    <= instrIf.instr[7:4];
                muxSel    <= 1'b0;
                inputData <= '0;
              end
              KIND_HALT: begin
                state  <= HALT;
                halted <= 1'b1;
              end
              default: illegal <= 1'b1;
            endcase
          end
        end
        SETUP: state <= WRITE;
        WRITE: begin
          state <= IDLE;
          if (retired != '1) retired <= retired + CNT_W'(1);
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Raised at the SETUP-cycle negedge and dropped at the WRITE-cycle negedge, so
  // clk & writeEnable rises exactly once, at the posedge that begins WRITE.
  always_ff @(negedge clk) begin
    if (reset) writeEnable <= 1'b0;
    else       writeEnable <= (state == SETUP);
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller with a small gated-clock register-file model.
module tb_datapath_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic       writeEnable, muxSel, halted, illegal;
  logic [7:0] inputData, retired;
  logic [3:0] dstSel, A_sel, B_sel, OP_Sel;
  logic       gclk;
  logic [7:0] rf [16];
  int         total = 0;
  int         bad = 0;
  int         gcount = 0;
  int         base;

  datapath_controller_if instrIf();

  datapath_controller #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instrIf(instrIf),
    .writeEnable(writeEnable), .muxSel(muxSel), .inputData(inputData),
    .dstSel(dstSel), .A_sel(A_sel), .B_sel(B_sel), .OP_Sel(OP_Sel),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return 8'h00;
    endcase
  endfunction

  // Datapath stand-in: register file clocked by the gated write clock.
  assign gclk = clk & writeEnable;
  always @(posedge gclk) begin
    gcount++;
    if (muxSel) rf[dstSel] <= inputData;
    else        rf[dstSel] <= aluModel(rf[A_sel], rf[B_sel], OP_Sel);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    instrIf.instr_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic sendWrite(input logic [23:0] word);
    instrIf.instr_valid = 1'b1;
    instrIf.instr = word;
    tick();
    chk("setupReady", 32'(instrIf.instr_ready), 32'd0);
    chk("setupWe", 32'(writeEnable), 32'd0);
    instrIf.instr_valid = 1'b0;
    tick();
    chk("writeReady", 32'(instrIf.instr_ready), 32'd0);
    chk("writeWe", 32'(writeEnable), 32'd1);
    tick();
    chk("idleReady", 32'(instrIf.instr_ready), 32'd1);
    chk("idleWe", 32'(writeEnable), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    instrIf.instr_valid = 1'b0;
    instrIf.instr = '0;
    tick();
    tick();
    chk("rstReady", 32'(instrIf.instr_ready), 32'd1);
    chk("rstWe", 32'(writeEnable), 32'd0);
    chk("rstRetired", 32'(retired), 32'd0);
    chk("rstHalted", 32'(halted), 32'd0);
    chk("rstIllegal", 32'(illegal), 32'd0);
    chk("rstDst", 32'(dstSel), 32'd0);
    chk("rstMux", 32'(muxSel), 32'd0);
    reset = 1'b0;
    base = gcount;

    // 1: LOADI R3 = 0x5A, cycle by cycle
    instrIf.instr_valid = 1'b1;
    instrIf.instr = 24'h13005A;
    tick();
    chk("t1SetupMux", 32'(muxSel), 32'd1);
    chk("t1SetupDst", 32'(dstSel), 32'd3);
    chk("t1SetupImm", 32'(inputData), 32'h5A);
    chk("t1SetupWe", 32'(writeEnable), 32'd0);
    chk("t1SetupReady", 32'(instrIf.instr_ready), 32'd0);
    instrIf.instr_valid = 1'b0;
    tick();
    chk("t1WriteWe", 32'(writeEnable), 32'd1);
    chk("t1WriteDst", 32'(dstSel), 32'd3);
    tick();
    chk("t1IdleWe", 32'(writeEnable), 32'd0);
    chk("t1Retired", 32'(retired), 32'd1);
    chk("t1Edges", 32'(gcount - base), 32'd1);
    chk("t1R3", 32'(rf[3]), 32'h5A);
    chk("t1HoldDst", 32'(dstSel), 32'd3);

    // 2: R1=7, R2=9, R4=R1+R2
    doReset();
    sendWrite(24'h110007);
    sendWrite(24'h120009);
    sendWrite(24'h241200);
    chk("t2R4", 32'(rf[4]), 32'h10);
    chk("t2Retired", 32'(retired), 32'd3);
    chk("t2Mux", 32'(muxSel), 32'd0);
    chk("t2A", 32'(A_sel), 32'd1);
    chk("t2B", 32'(B_sel), 32'd2);
    chk("t2Imm", 32'(inputData), 32'd0);

    // 3: NOPs back to back with valid held
    doReset();
    base = gcount;
    instrIf.instr_valid = 1'b1;
    instrIf.instr = 24'h0ABCDE;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3Ready", 32'(instrIf.instr_ready), 32'd1);
      chk("t3We", 32'(writeEnable), 32'd0);
    end
    instrIf.instr_valid = 1'b0;
    chk("t3Retired", 32'(retired), 32'd0);
    chk("t3Edges", 32'(gcount - base), 32'd0);

    // 4: illegal kind is sticky and behaves as NOP
    instrIf.instr_valid = 1'b1;
    instrIf.instr = 24'h7FFFFF;
    tick();
    chk("t4Illegal", 32'(illegal), 32'd1);
    chk("t4Ready", 32'(instrIf.instr_ready), 32'd1);
    instrIf.instr_valid = 1'b0;
    tick();
    chk("t4Sticky", 32'(illegal), 32'd1);
    chk("t4Edges", 32'(gcount - base), 32'd0);
    sendWrite(24'h150033);
    chk("t4R5", 32'(rf[5]), 32'h33);
    chk("t4Retired", 32'(retired), 32'd1);
    chk("t4StillIllegal", 32'(illegal), 32'd1);

    // 5: HALT, then a held LOADI is never consumed
    base = gcount;
    instrIf.instr_valid = 1'b1;
    instrIf.instr = 24'hF00000;
    tick();
    chk("t5Halted", 32'(halted), 32'd1);
    chk("t5Ready", 32'(instrIf.instr_ready), 32'd0);
    instrIf.instr = 24'h1600AA;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5HeldReady", 32'(instrIf.instr_ready), 32'd0);
      chk("t5HeldHalted", 32'(halted), 32'd1);
    end
    chk("t5Edges", 32'(gcount - base), 32'd0);
    chk("t5Retired", 32'(retired), 32'd1);
    instrIf.instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("t5RstReady", 32'(instrIf.instr_ready), 32'd1);
    chk("t5RstHalted", 32'(halted), 32'd0);
    chk("t5RstIllegal", 32'(illegal), 32'd0);
    reset = 1'b0;

    // 6a: reset during SETUP suppresses the write edge
    base = gcount;
    instrIf.instr_valid = 1'b1;
    instrIf.instr = 24'h180088;
    tick();
    instrIf.instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("t6aWe", 32'(writeEnable), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("t6aEdges", 32'(gcount - base), 32'd0);
    chk("t6aRetired", 32'(retired), 32'd0);
    chk("t6aDst", 32'(dstSel), 32'd0);

    // 6b: reset during WRITE aborts without counting
    instrIf.instr_valid = 1'b1;
    instrIf.instr = 24'h170077;
    tick();
    instrIf.instr_valid = 1'b0;
    tick();
    chk("t6bWriteWe", 32'(writeEnable), 32'd1);
    reset = 1'b1;
    base = gcount;
    tick();
    chk("t6bWe", 32'(writeEnable), 32'd0);
    chk("t6bRetired", 32'(retired), 32'd0);
    chk("t6bReady", 32'(instrIf.instr_ready), 32'd1);
    reset = 1'b0;
    tick();
    tick();
    chk("t6bEdges", 32'(gcount - base), 32'd0);
    chk("t6bRetiredLater", 32'(retired), 32'd0);

    // 6c: retired saturates at 255
    doReset();
    for (int i = 0; i < 254; i++) sendWrite(24'h190000 | 24'(i & 8'hFF));
    chk("t6cAt254", 32'(retired), 32'hFE);
    for (int i = 0; i < 46; i++) sendWrite(24'h1A0011);
    chk("t6cSat", 32'(retired), 32'hFF);
    chk("t6cR10", 32'(rf[10]), 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
